serial_mod_checker: RTL and testbench

- Parametrised serial divisibility checker. Accepts an unsigned number MSB-first, BITS_PER_CYCLE bits per accepted beat, and tracks its running remainder modulo DIVISOR.
- Flags when the number received so far is an exact multiple of DIVISOR.
- Generalises the fixed divide-by-5, 1-bit-per-cycle checker:
  - programmable divisor;
  - multi-bit beats;
  - input qualifier;
  - in-band frame restart;
  - remainder and bit-count visibility.
- Sits on serial stream paths as a checksum/framing-check primitive.

---
 rtl/serial_mod_checker_if.sv | 27 ++
 rtl/serial_mod_checker.sv | 65 ++++++
 tb/tb_serial_mod_checker.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_mod_checker_if.sv
// Stream-side bundle for serial_mod_checker: beat input, restart strobe and
// the registered remainder/status view.
interface serial_mod_checker_if #(
   parameter int DIVISOR        = 5,
   parameter int BITS_PER_CYCLE = 1,
   parameter int CNT_W          = 16
);
   localparam int REM_W = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR);

   logic                      din_valid;
   logic [BITS_PER_CYCLE-1:0] din;
   logic                      clear;
   logic                      dout;
   logic [REM_W-1:0]          rem;
   logic                      seen;
   logic [CNT_W-1:0]          nbits;

   modport master (
      output din_valid, din, clear,
      input  dout, rem, seen, nbits
   );

   modport slave (
      input  din_valid, din, clear,
      output dout, rem, seen, nbits
   );
endinterface

// File: rtl/serial_mod_checker.sv
// Serial divisibility checker: folds an MSB-first number, BITS_PER_CYCLE bits
// per accepted beat, into a running remainder modulo DIVISOR.
module serial_mod_checker #(
   parameter int DIVISOR        = 5,
   parameter int BITS_PER_CYCLE = 1,
   parameter int CNT_W          = 16
) (
   input logic             clk,
   input logic             reset,
   serial_mod_checker_if.slave bus
);
   localparam int REM_W = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR);
   localparam int SUM_W = CNT_W + 4;
   localparam logic [REM_W:0]   DIV_R = DIVISOR[REM_W:0];
   localparam logic [SUM_W-1:0] BPC   = SUM_W'(BITS_PER_CYCLE);

   logic [REM_W-1:0] rem_q;
   logic             seen_q;
   logic [CNT_W-1:0] nbits_q;

   logic [REM_W-1:0] rem_nxt;
   logic [REM_W:0]   step;
   logic [SUM_W-1:0] nb_sum;
   logic [CNT_W-1:0] nb_nxt;

   // Shift-and-subtract chain: each step stays below 2*DIVISOR, so one
   // conditional subtract keeps the remainder reduced.
   always_comb begin
      rem_nxt = bus.clear ? '0 : rem_q;
      step    = '0;
      for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
         step = {rem_nxt, bus.din[i]};
         if (step >= DIV_R) begin
            step = step - DIV_R;
         end
         rem_nxt = step[REM_W-1:0];
      end
   end

   always_comb begin
      nb_sum = (bus.clear ? '0 : {{(SUM_W-CNT_W){1'b0}}, nbits_q}) + BPC;
      nb_nxt = (|nb_sum[SUM_W-1:CNT_W]) ? '1 : nb_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q   <= '0;
         seen_q  <= 1'b0;
         nbits_q <= '0;
      end else if (bus.din_valid) begin
         rem_q   <= rem_nxt;
         seen_q  <= 1'b1;
         nbits_q <= nb_nxt;
      end else if (bus.clear) begin
         rem_q   <= '0;
         seen_q  <= 1'b0;
         nbits_q <= '0;
      end
   end

   assign bus.rem   = rem_q;
   assign bus.seen  = seen_q;
   assign bus.nbits = nbits_q;
   assign bus.dout  = seen_q & (rem_q == '0);
endmodule

// File: tb/tb_serial_mod_checker.sv
// Directed vector table on four fixed configurations plus randomised streams
// on twelve divisor/beat-width combinations, all checked through queues.
module tb_serial_mod_checker;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int rdone = 0;

   typedef struct {
      int         id;
      int         d;
      bit         r;
      bit         v;
      bit         c;
      logic [7:0] din;
      int         rem;
      bit         dout;
      bit         seen;
      int         nb;
   } vec_t;

   typedef struct {
      int rem;
      bit dout;
      bit seen;
      int nb;
   } exp_t;

   task automatic chk(string nm, int id, int r, bit d, bit s, int n, int er, bit ed, bit es, int en);
      total++;
      if (r != er || d != ed || s != es || n != en) begin
         bad++;
         $display("FAIL %s#%0d rem/dout/seen/nbits got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
                  nm, id, r, d, s, n, er, ed, es, en);
      end
   endtask

   // ---------------- directed instances ----------------
   logic       dr[4];
   logic       dv[4];
   logic       dc[4];
   logic [7:0] dd[4];
   logic [7:0] o_rem[4];
   logic       o_dout[4];
   logic       o_seen[4];
   logic [15:0] o_nb[4];

   serial_mod_checker_if #(.DIVISOR(5), .BITS_PER_CYCLE(1), .CNT_W(16)) if0();
   serial_mod_checker_if #(.DIVISOR(3), .BITS_PER_CYCLE(2), .CNT_W(16)) if1();
   serial_mod_checker_if #(.DIVISOR(7), .BITS_PER_CYCLE(1), .CNT_W(16)) if2();
   serial_mod_checker_if #(.DIVISOR(9), .BITS_PER_CYCLE(3), .CNT_W(4))  if3();

   serial_mod_checker #(.DIVISOR(5), .BITS_PER_CYCLE(1), .CNT_W(16)) u0 (.clk(clk), .reset(dr[0]), .bus(if0));
   serial_mod_checker #(.DIVISOR(3), .BITS_PER_CYCLE(2), .CNT_W(16)) u1 (.clk(clk), .reset(dr[1]), .bus(if1));
   serial_mod_checker #(.DIVISOR(7), .BITS_PER_CYCLE(1), .CNT_W(16)) u2 (.clk(clk), .reset(dr[2]), .bus(if2));
   serial_mod_checker #(.DIVISOR(9), .BITS_PER_CYCLE(3), .CNT_W(4))  u3 (.clk(clk), .reset(dr[3]), .bus(if3));

   assign if0.din_valid = dv[0]; assign if0.clear = dc[0]; assign if0.din = dd[0][0:0];
   assign if1.din_valid = dv[1]; assign if1.clear = dc[1]; assign if1.din = dd[1][1:0];
   assign if2.din_valid = dv[2]; assign if2.clear = dc[2]; assign if2.din = dd[2][0:0];
   assign if3.din_valid = dv[3]; assign if3.clear = dc[3]; assign if3.din = dd[3][2:0];

   assign o_rem[0] = 8'(if0.rem); assign o_dout[0] = if0.dout; assign o_seen[0] = if0.seen; assign o_nb[0] = if0.nbits;
   assign o_rem[1] = 8'(if1.rem); assign o_dout[1] = if1.dout; assign o_seen[1] = if1.seen; assign o_nb[1] = if1.nbits;
   assign o_rem[2] = 8'(if2.rem); assign o_dout[2] = if2.dout; assign o_seen[2] = if2.seen; assign o_nb[2] = if2.nbits;
   assign o_rem[3] = 8'(if3.rem); assign o_dout[3] = if3.dout; assign o_seen[3] = if3.seen; assign o_nb[3] = 16'(if3.nbits);

   vec_t tbl[$];
   vec_t dq[$];

   task automatic add(int d, bit r, bit v, bit c, logic [7:0] din, int rem, bit dout, bit seen, int nb);
      vec_t t;
      t = '{tbl.size(), d, r, v, c, din, rem, dout, seen, nb};
      tbl.push_back(t);
   endtask

   task automatic pop_dir();
      vec_t e;
      e = dq.pop_front();
      chk("dir", e.id, int'(o_rem[e.d]), o_dout[e.d], o_seen[e.d], int'(o_nb[e.d]),
          e.rem, e.dout, e.seen, e.nb);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         dr[i] = 1'b0; dv[i] = 1'b0; dc[i] = 1'b0; dd[i] = 8'h00;
      end
      // div5 b1: reset with valid high must still zero everything
      add(0, 1, 1, 0, 1, 0, 0, 0, 0);
      add(0, 0, 1, 0, 1, 1, 0, 1, 1);
      add(0, 0, 1, 0, 0, 2, 0, 1, 2);
      add(0, 0, 1, 0, 1, 0, 1, 1, 3);
      add(0, 0, 1, 0, 0, 0, 1, 1, 4);
      // 1,1,<idle x2, garbage din>,1,1
      add(0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 1, 1, 0, 1, 1);
      add(0, 0, 1, 0, 1, 3, 0, 1, 2);
      add(0, 0, 0, 0, 8'hff, 3, 0, 1, 2);
      add(0, 0, 0, 0, 8'hff, 3, 0, 1, 2);
      add(0, 0, 1, 0, 1, 2, 0, 1, 3);
      add(0, 0, 1, 0, 1, 0, 1, 1, 4);
      // mid-number reset discards history
      add(0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 1, 1, 0, 1, 1);
      add(0, 0, 1, 0, 0, 2, 0, 1, 2);
      add(0, 0, 1, 0, 1, 0, 1, 1, 3);
      add(0, 1, 1, 0, 1, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 1, 1, 1);
      // div3 b2: 3, 13, 54
      add(1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 1, 0, 3, 0, 1, 1, 2);
      add(1, 0, 1, 0, 1, 1, 0, 1, 4);
      add(1, 0, 1, 0, 2, 0, 1, 1, 6);
      // div7 b1: 1,1,0 then in-band restart
      add(2, 1, 0, 0, 0, 0, 0, 0, 0);
      add(2, 0, 1, 0, 1, 1, 0, 1, 1);
      add(2, 0, 1, 0, 1, 3, 0, 1, 2);
      add(2, 0, 1, 0, 0, 6, 0, 1, 3);
      add(2, 0, 1, 1, 1, 1, 0, 1, 1);
      add(2, 0, 0, 1, 1, 0, 0, 0, 0);
      add(2, 0, 1, 1, 0, 0, 1, 1, 1);
      // div9 b3 cnt4: counter saturation leaves rem alone
      add(3, 1, 0, 0, 0, 0, 0, 0, 0);
      add(3, 0, 1, 0, 0, 0, 1, 1, 3);
      add(3, 0, 1, 0, 0, 0, 1, 1, 6);
      add(3, 0, 1, 0, 0, 0, 1, 1, 9);
      add(3, 0, 1, 0, 0, 0, 1, 1, 12);
      add(3, 0, 1, 0, 0, 0, 1, 1, 15);
      add(3, 0, 1, 0, 0, 0, 1, 1, 15);
      add(3, 0, 1, 0, 7, 7, 0, 1, 15);

      foreach (tbl[k]) begin
         @(negedge clk);
         if (dq.size() > 0) pop_dir();
         for (int i = 0; i < 4; i++) begin
            dr[i] = 1'b0; dv[i] = 1'b0; dc[i] = 1'b0; dd[i] = 8'hff;
         end
         dr[tbl[k].d] = tbl[k].r;
         dv[tbl[k].d] = tbl[k].v;
         dc[tbl[k].d] = tbl[k].c;
         dd[tbl[k].d] = tbl[k].din;
         dq.push_back(tbl[k]);
      end
      @(negedge clk);
      if (dq.size() > 0) pop_dir();
      for (int i = 0; i < 4; i++) begin
         dr[i] = 1'b0; dv[i] = 1'b0; dc[i] = 1'b0;
      end

      for (int c = 0; c < 40000 && rdone < 12; c++) @(negedge clk);
      if (rdone < 12) begin
         total++;
         bad++;
         $display("FAIL random_timeout done got=%0d want=12", rdone);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // ---------------- randomised instances ----------------
   for (genvar gd = 0; gd < 4; gd++) begin : g_d
      for (genvar gb = 0; gb < 3; gb++) begin : g_b
         localparam int D = (gd == 0) ? 2 : (gd == 1) ? 5 : (gd == 2) ? 13 : 255;
         localparam int B = (gb == 0) ? 1 : (gb == 1) ? 4 : 8;
         localparam int NBMAX = 65535;

         logic rr;
         serial_mod_checker_if #(.DIVISOR(D), .BITS_PER_CYCLE(B), .CNT_W(16)) rif();
         serial_mod_checker #(.DIVISOR(D), .BITS_PER_CYCLE(B), .CNT_W(16)) u (.clk(clk), .reset(rr), .bus(rif));

         exp_t q[$];

         initial begin
            int   m, nb, acc, xv, beat;
            bit   sn, v, c;
            exp_t e;
            logic [7:0] xb;
            m = 0; nb = 0; sn = 0; acc = 0; beat = 0;
            rr = 1'b1; rif.din_valid = 1'b1; rif.clear = 1'b0; rif.din = '1;
            q.push_back('{0, 0, 0, 0});
            while (acc < 10000) begin
               @(negedge clk);
               e = q.pop_front();
               chk($sformatf("rnd_d%0d_b%0d", D, B), beat,
                   int'(rif.rem), rif.dout, rif.seen, int'(rif.nbits),
                   e.rem, e.dout, e.seen, e.nb);
               beat++;
               rr = 1'b0;
               v  = ($urandom_range(0, 4) != 0);
               c  = ($urandom_range(0, 99) == 0);
               xv = int'($urandom_range(0, (1 << B) - 1));
               xb = 8'(xv);
               rif.din_valid = v;
               rif.clear     = c;
               rif.din       = xb[B-1:0];
               if (v) begin
                  acc++;
                  if (c) begin
                     m  = xv % D;
                     nb = B;
                  end else begin
                     m  = (m * (1 << B) + xv) % D;
                     nb = (nb + B > NBMAX) ? NBMAX : nb + B;
                  end
                  sn = 1'b1;
               end else if (c) begin
                  m = 0; nb = 0; sn = 1'b0;
               end
               q.push_back('{m, sn && (m == 0), sn, nb});
            end
            @(negedge clk);
            e = q.pop_front();
            chk($sformatf("rnd_d%0d_b%0d", D, B), beat,
                int'(rif.rem), rif.dout, rif.seen, int'(rif.nbits),
                e.rem, e.dout, e.seen, e.nb);
            rif.din_valid = 1'b0;
            rif.clear     = 1'b0;
            rdone++;
         end
      end
   end
endmodule
